// File: rtl/executor_pkg.sv
// executor_pkg: definitions shared by the execute stage.
//   - ARM condition-code field encodings (EQ..NV)
//   - bit positions of the flags inside a {N,Z,C,V} vector
//   - ALU opcode encodings (data-processing opcode field)
package executor_pkg;

   // Condition field encodings
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // Flag positions inside a {N,Z,C,V} vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // ALU opcodes
   typedef enum logic [3:0] {
      OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
      OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
      OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
      OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
   } alu_op_e;

endpackage

// File: rtl/executor_flags_if.sv
// Bus interfaces of the execute-stage flag/writeback block.
//
// executor_alu_if : ALU -> executor_flags word plus the carry fed back.
//   master = ALU side, slave = executor_flags side.
// executor_wb_if  : executor_flags -> register file writeback port.
//   master = executor_flags side, slave = register file side.
//
// Handshake (both buses): a word transfers on a rising edge where
// valid=1 and ready=1. While valid=1 and ready=0 the producer holds its
// payload stable; ready may depend on valid only combinationally on the
// consumer side, never the other way round.

interface executor_alu_if #(
   parameter int DW = 32,
   parameter int RW = 4
);
   logic          alu_valid;
   logic          alu_ready;
   logic [DW-1:0] alu_result;
   logic          alu_n;
   logic          alu_z;
   logic          alu_c;
   logic          alu_v;
   logic          alu_s;
   logic          alu_logic;
   logic          alu_we;
   logic [RW-1:0] alu_rd;
   logic          c_to_alu;

   modport master (
      output alu_valid, alu_result, alu_n, alu_z, alu_c, alu_v,
             alu_s, alu_logic, alu_we, alu_rd,
      input  alu_ready, c_to_alu
   );

   modport slave (
      input  alu_valid, alu_result, alu_n, alu_z, alu_c, alu_v,
             alu_s, alu_logic, alu_we, alu_rd,
      output alu_ready, c_to_alu
   );
endinterface

interface executor_wb_if #(
   parameter int DW = 32,
   parameter int RW = 4
);
   logic          wb_valid;
   logic          wb_ready;
   logic [RW-1:0] wb_rd;
   logic [DW-1:0] wb_data;

   modport master (
      output wb_valid, wb_rd, wb_data,
      input  wb_ready
   );

   modport slave (
      input  wb_valid, wb_rd, wb_data,
      output wb_ready
   );
endinterface

// File: rtl/executor_flags_cond_eval.sv
// cond_eval: combinational ARM condition-code evaluator.
//   cond_i  [3:0] condition field
//   nzcv_i  [3:0] flags {N,Z,C,V}
//   pass_o        1 when the condition holds
// NV_PASS selects the result for the NV (4'hF) encoding.
module cond_eval
   import executor_pkg::*;
#(
   parameter bit NV_PASS = 1'b0
) (
   input  logic [3:0] cond_i,
   input  logic [3:0] nzcv_i,
   output logic       pass_o
);

   logic n, z, c, v;

   always_comb begin
      n      = nzcv_i[FLAG_N];
      z      = nzcv_i[FLAG_Z];
      c      = nzcv_i[FLAG_C];
      v      = nzcv_i[FLAG_V];
      pass_o = 1'b0;
      case (cond_i)
         COND_EQ: pass_o = z;
         COND_NE: pass_o = ~z;
         COND_CS: pass_o = c;
         COND_CC: pass_o = ~c;
         COND_MI: pass_o = n;
         COND_PL: pass_o = ~n;
         COND_VS: pass_o = v;
         COND_VC: pass_o = ~v;
         COND_HI: pass_o = c & ~z;
         COND_LS: pass_o = ~c | z;
         COND_GE: pass_o = (n == v);
         COND_LT: pass_o = (n != v);
         COND_GT: pass_o = ~z & (n == v);
         COND_LE: pass_o = z | (n != v);
         COND_AL: pass_o = 1'b1;
         COND_NV: pass_o = NV_PASS;
         default: pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/executor_flags.sv
// executor_flags: consumer end of the execute-stage ALU bus.
//   clk, rst_n       clock, async active-low reset
//   alu (slave)      ALU result/flags word with valid/ready, carry back
//   wb  (master)     one-entry buffered register writeback
//   cond, cond_pass  condition of the next instruction, evaluated on
//                    forwarded flags
//   msr_we, msr_nzcv direct flag write, wins over an ALU update
//   nzcv             architectural flags {N,Z,C,V}
module executor_flags
   import executor_pkg::*;
#(
   parameter int DW      = 32,
   parameter int RW      = 4,
   parameter bit NV_PASS = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   executor_alu_if.slave     alu,
   executor_wb_if.master     wb,
   input  logic [3:0]        cond,
   output logic              cond_pass,
   input  logic              msr_we,
   input  logic [3:0]        msr_nzcv,
   output logic [3:0]        nzcv
);

   logic [3:0]    nzcv_q, nzcv_d;
   logic          wb_valid_q, wb_valid_d;
   logic [RW-1:0] wb_rd_q, wb_rd_d;
   logic [DW-1:0] wb_data_q, wb_data_d;

   logic          accept;
   logic [3:0]    alu_nzcv;

   // A full entry only blocks the ALU if the register file is not
   // taking it this cycle, so the slot can be refilled back-to-back.
   assign alu.alu_ready = ~wb_valid_q | wb.wb_ready;
   assign accept        = alu.alu_valid & alu.alu_ready;

   // Logical/move ops leave V untouched.
   assign alu_nzcv = {alu.alu_n, alu.alu_z, alu.alu_c,
                      alu.alu_logic ? nzcv_q[FLAG_V] : alu.alu_v};

   // Forwarded flags are exactly the next register value, so the
   // condition for the following instruction sees this cycle's update.
   always_comb begin
      nzcv_d = nzcv_q;
      if (msr_we)
         nzcv_d = msr_nzcv;
      else if (accept && alu.alu_s)
         nzcv_d = alu_nzcv;
   end

   always_comb begin
      wb_valid_d = wb_valid_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      if (accept && alu.alu_we) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = alu.alu_rd;
         wb_data_d  = alu.alu_result;
      end else if (wb.wb_ready) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nzcv_q     <= 4'b0000;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         nzcv_q     <= nzcv_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
      end
   end

   cond_eval #(
      .NV_PASS (NV_PASS)
   ) u_cond_eval (
      .cond_i  (cond),
      .nzcv_i  (nzcv_d),
      .pass_o  (cond_pass)
   );

   // Registered carry only: forwarding it would close a loop through
   // the ALU adder.
   assign alu.c_to_alu = nzcv_q[FLAG_C];

   assign nzcv        = nzcv_q;
   assign wb.wb_valid = wb_valid_q;
   assign wb.wb_rd    = wb_rd_q;
   assign wb.wb_data  = wb_data_q;

endmodule

// File: tb/tb_executor_flags.sv
`timescale 1ns/1ps
module tb_executor_flags;

   localparam int DW = 32;
   localparam int RW = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] cond;
   logic       cond_pass;
   logic       msr_we;
   logic [3:0] msr_nzcv;
   logic [3:0] nzcv;

   executor_alu_if #(.DW(DW), .RW(RW)) alu_bus ();
   executor_wb_if  #(.DW(DW), .RW(RW)) wb_bus ();

   executor_flags #(.DW(DW), .RW(RW), .NV_PASS(1'b0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu       (alu_bus),
      .wb        (wb_bus),
      .cond      (cond),
      .cond_pass (cond_pass),
      .msr_we    (msr_we),
      .msr_nzcv  (msr_nzcv),
      .nzcv      (nzcv)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- counters / scoreboard ----------------
   int n_total = 0;
   int n_bad   = 0;
   logic [RW+DW-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference condition model: ARM pairs share a base test, odd codes invert it.
   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      if (c == 4'hE) return 1'b1;
      if (c == 4'hF) return 1'b0;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n ~^ v);
         default: base = !z && (n ~^ v);
      endcase
      return c[0] ? !base : base;
   endfunction

   // Writeback monitor: every consumed entry must match the oldest expected one.
   always @(negedge clk) begin
      if (rst_n && wb_bus.wb_valid === 1'b1 && wb_bus.wb_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", {31'b0, wb_bus.wb_valid}, 32'd0);
         end else begin
            logic [RW+DW-1:0] e;
            e = exp_q.pop_front();
            chk("wb_rd",   {28'b0, wb_bus.wb_rd}, {28'b0, e[RW+DW-1:DW]});
            chk("wb_data", wb_bus.wb_data, e[DW-1:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_drive(input logic v, input logic s, input logic lg, input logic we,
                            input logic [RW-1:0] rd, input logic [DW-1:0] data,
                            input logic [3:0] f);
      alu_bus.alu_valid  = v;
      alu_bus.alu_s      = s;
      alu_bus.alu_logic  = lg;
      alu_bus.alu_we     = we;
      alu_bus.alu_rd     = rd;
      alu_bus.alu_result = data;
      alu_bus.alu_n      = f[3];
      alu_bus.alu_z      = f[2];
      alu_bus.alu_c      = f[1];
      alu_bus.alu_v      = f[0];
   endtask

   task automatic alu_idle();
      alu_drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 4'b0000);
   endtask

   // ---------------- directed sequence ----------------
   logic [3:0] sweep_vals[6];

   initial begin
      sweep_vals = '{4'b0000, 4'b0100, 4'b1001, 4'b0110, 4'b1111, 4'b0011};
      rst_n = 1'b0;
      cond = 4'h0;
      msr_we = 1'b0;
      msr_nzcv = 4'h0;
      wb_bus.wb_ready = 1'b1;
      alu_idle();

      // Reset state
      #1;
      chk("rst_nzcv", {28'b0, nzcv}, 32'd0);
      chk("rst_wb_valid", {31'b0, wb_bus.wb_valid}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("rst_wb_rd", {28'b0, wb_bus.wb_rd}, 32'd0);
      chk("rst_wb_data", wb_bus.wb_data, 32'd0);
      chk("rst_c_to_alu", {31'b0, alu_bus.c_to_alu}, 32'd0);
      chk("rst_alu_ready", {31'b0, alu_bus.alu_ready}, 32'd1);
      cond = 4'hE; #1;
      chk("rst_cond_al", {31'b0, cond_pass}, 32'd1);
      cond = 4'h0; #1;
      chk("rst_cond_eq", {31'b0, cond_pass}, 32'd0);

      // Flag update with same-cycle forwarding
      tick();
      alu_drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'h0, 4'b0110);
      cond = 4'h0;
      exp_q.push_back({4'd1, 32'h0});
      #1;
      chk("fwd_eq_pass", {31'b0, cond_pass}, 32'd1);
      tick();
      alu_idle();
      chk("upd_nzcv", {28'b0, nzcv}, 32'h6);
      chk("upd_c_to_alu", {31'b0, alu_bus.c_to_alu}, 32'd1);
      chk("upd_wb_valid", {31'b0, wb_bus.wb_valid}, 32'd1);

      // Logic op keeps V
      msr_we = 1'b1; msr_nzcv = 4'b0001;
      tick();
      msr_we = 1'b0;
      chk("msr_nzcv", {28'b0, nzcv}, 32'h1);
      alu_drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'hA5, 4'b1000);
      exp_q.push_back({4'd2, 32'hA5});
      tick();
      alu_idle();
      chk("logic_keep_v", {28'b0, nzcv}, 32'h9);
      chk("logic_c_to_alu", {31'b0, alu_bus.c_to_alu}, 32'd0);

      // Compare: flags only, no writeback entry
      alu_drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'hFFFF_FFFF, 4'b1010);
      tick();
      alu_idle();
      chk("cmp_wb_valid", {31'b0, wb_bus.wb_valid}, 32'd0);
      chk("cmp_nzcv", {28'b0, nzcv}, 32'hA);
      cond = 4'hB; #1;
      chk("cmp_lt_pass", {31'b0, cond_pass}, 32'd1);
      cond = 4'hA; #1;
      chk("cmp_ge_fail", {31'b0, cond_pass}, 32'd0);

      // Backpressure
      tick();
      wb_bus.wb_ready = 1'b0;
      alu_drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'h1234_5678, 4'b0000);
      exp_q.push_back({4'd3, 32'h1234_5678});
      tick();
      alu_drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 32'hDEAD_BEEF, 4'b0000);
      #1;
      chk("bp_alu_ready", {31'b0, alu_bus.alu_ready}, 32'd0);
      chk("bp_wb_valid", {31'b0, wb_bus.wb_valid}, 32'd1);
      tick();
      chk("bp_hold_rd", {28'b0, wb_bus.wb_rd}, 32'd3);
      chk("bp_hold_data", wb_bus.wb_data, 32'h1234_5678);
      chk("bp_flags_ignored", {28'b0, nzcv}, 32'hA);
      wb_bus.wb_ready = 1'b1;
      exp_q.push_back({4'd4, 32'hDEAD_BEEF});
      #1;
      chk("bp_release_ready", {31'b0, alu_bus.alu_ready}, 32'd1);
      tick();
      alu_idle();
      chk("bp_second_rd", {28'b0, wb_bus.wb_rd}, 32'd4);
      chk("bp_second_nzcv", {28'b0, nzcv}, 32'h0);
      tick();
      chk("bp_drained", {31'b0, wb_bus.wb_valid}, 32'd0);

      // MSR collides with an accepted S-update
      msr_we = 1'b1; msr_nzcv = 4'b1010;
      alu_drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 4'b0101);
      cond = 4'hA; #1;
      chk("msr_col_ge", {31'b0, cond_pass}, 32'd0);
      cond = 4'hB; #1;
      chk("msr_col_lt", {31'b0, cond_pass}, 32'd1);
      tick();
      msr_we = 1'b0;
      alu_idle();
      chk("msr_col_nzcv", {28'b0, nzcv}, 32'hA);

      // Condition table sweep on forwarded MSR values
      foreach (sweep_vals[i]) begin
         msr_we = 1'b1; msr_nzcv = sweep_vals[i];
         for (int k = 0; k < 16; k++) begin
            logic [3:0] c4;
            c4 = k[3:0];
            cond = c4;
            #1;
            chk($sformatf("cond_%h_f%b", c4, sweep_vals[i]), {31'b0, cond_pass},
                {31'b0, ref_cond(c4, sweep_vals[i])});
         end
      end
      msr_we = 1'b0;
      tick();
      chk("sweep_nzcv", {28'b0, nzcv}, 32'h3);

      // Reset mid-operation drops the pending entry
      wb_bus.wb_ready = 1'b0;
      alu_drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 32'h77, 4'b1111);
      exp_q.push_back({4'd7, 32'h77});
      tick();
      alu_idle();
      chk("pre_rst_nzcv", {28'b0, nzcv}, 32'hF);
      chk("pre_rst_wb_valid", {31'b0, wb_bus.wb_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      chk("mid_rst_nzcv", {28'b0, nzcv}, 32'h0);
      chk("mid_rst_wb_valid", {31'b0, wb_bus.wb_valid}, 32'd0);
      chk("mid_rst_c_to_alu", {31'b0, alu_bus.c_to_alu}, 32'd0);
      tick();
      rst_n = 1'b1;
      wb_bus.wb_ready = 1'b1;
      tick(); tick();
      chk("post_rst_wb_valid", {31'b0, wb_bus.wb_valid}, 32'd0);
      chk("exp_q_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
